// File: rtl/mitm_logic.sv
// SPI man-in-the-middle sequencer: requests instruction/address/data chunks from the
// bus controller and substitutes MISO data on reads. Optional macro: MITM_ADDR_ECHO_EN.
module mitm_logic #(
  parameter int                    BUF_SIZE          = 9,
  parameter int                    MODE_WIDTH        = 2,
  parameter logic [MODE_WIDTH-1:0] MITM_MODE_FORWARD = 2'b01,
  parameter logic [MODE_WIDTH-1:0] MITM_MODE_SUB_ALL = 2'b10,
  localparam int                   CHUNK_SIZE_WIDTH  = $clog2(BUF_SIZE + 1)
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic [MODE_WIDTH-1:0]       mode_select,
  input  logic                        comm_active,
  input  logic                        bus_ready,
  input  logic [BUF_SIZE-1:0]         real_miso_data,
  input  logic [BUF_SIZE-1:0]         real_mosi_data,
  output logic                        cmd_next_chunk,
  output logic                        cmd_finish,
  output logic [CHUNK_SIZE_WIDTH-1:0] next_chunk_size,
  output logic                        fake_miso_select,
  output logic                        fake_mosi_select,
  output logic [BUF_SIZE-1:0]         fake_miso_data,
  output logic [BUF_SIZE-1:0]         fake_mosi_data
);

  typedef enum logic [2:0] {
    IDLE, REQ_INSTR, REQ_ADDR, REQ_DATA, WAIT_BUSY, WAIT_DONE, FINISH, WAIT_END
  } state_t;

  // Which chunk is in flight while sitting in WAIT_BUSY / WAIT_DONE.
  typedef enum logic [1:0] { PH_INSTR, PH_ADDR, PH_DATA } phase_t;

  localparam logic [2:0] OP_READ = 3'b110;

  state_t                state_q, state_d;
  phase_t                phase_q, phase_d;
  logic [MODE_WIDTH-1:0] mode_q, mode_d;
  logic [BUF_SIZE-1:0]   addr_q, addr_d;
  logic [BUF_SIZE-1:0]   fake_val;
  logic                  unused_inputs;

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      state_q <= IDLE;
      phase_q <= PH_INSTR;
      mode_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    if (state_q != IDLE && !comm_active) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (comm_active && bus_ready) begin
          mode_d  = (mode_select == MITM_MODE_SUB_ALL) ? MITM_MODE_SUB_ALL : MITM_MODE_FORWARD;
          state_d = REQ_INSTR;
        end
        REQ_INSTR: begin phase_d = PH_INSTR; state_d = WAIT_BUSY; end
        REQ_ADDR:  begin phase_d = PH_ADDR;  state_d = WAIT_BUSY; end
        REQ_DATA:  begin phase_d = PH_DATA;  state_d = WAIT_BUSY; end
        WAIT_BUSY: if (!bus_ready) state_d = WAIT_DONE;
        WAIT_DONE: if (bus_ready) begin
          unique case (phase_q)
            PH_INSTR: state_d = (real_mosi_data[2:0] == OP_READ) ? REQ_ADDR : FINISH;
            PH_ADDR:
              if (mode_q == MITM_MODE_SUB_ALL) begin
                addr_d  = real_mosi_data;
                state_d = REQ_DATA;
              end else begin
                state_d = FINISH;
              end
            default:  state_d = FINISH;
          endcase
        end
        FINISH:   state_d = WAIT_END;
        WAIT_END: state_d = WAIT_END;
        default:  state_d = IDLE;
      endcase
    end
  end

`ifdef MITM_ADDR_ECHO_EN
  assign fake_val = BUF_SIZE'(addr_q[7:0]);
`else
  assign fake_val = BUF_SIZE'(8'hA5);
`endif

  // Outputs decode from state only, so a reset or abort edge clears them all at once.
  always_comb begin
    cmd_next_chunk   = 1'b0;
    cmd_finish       = 1'b0;
    next_chunk_size  = '0;
    fake_miso_select = 1'b0;
    unique case (state_q)
      REQ_INSTR: begin cmd_next_chunk = 1'b1; next_chunk_size = CHUNK_SIZE_WIDTH'(3); end
      REQ_ADDR:  begin cmd_next_chunk = 1'b1; next_chunk_size = CHUNK_SIZE_WIDTH'(BUF_SIZE); end
      REQ_DATA:  begin
        cmd_next_chunk   = 1'b1;
        next_chunk_size  = CHUNK_SIZE_WIDTH'(8);
        fake_miso_select = 1'b1;
      end
      WAIT_BUSY, WAIT_DONE: fake_miso_select = (phase_q == PH_DATA);
      FINISH:  cmd_finish = 1'b1;
      default: ;
    endcase
  end

  assign fake_miso_data   = fake_miso_select ? fake_val : '0;
  assign fake_mosi_select = 1'b0;
  assign fake_mosi_data   = '0;
  assign unused_inputs    = ^{real_miso_data, addr_q};

endmodule

// File: tb/tb_mitm_logic.sv
// Directed self-checking bench for mitm_logic: forward, substitute, write, abort, reset.
module tb_mitm_logic;
  logic       sys_clk, rst, comm_active, bus_ready;
  logic [1:0] mode_select;
  logic [8:0] real_miso_data, real_mosi_data;
  logic       cmd_next_chunk, cmd_finish, fake_miso_select, fake_mosi_select;
  logic [3:0] next_chunk_size;
  logic [8:0] fake_miso_data, fake_mosi_data;
  int checks = 0, errors = 0;

`ifdef MITM_ADDR_ECHO_EN
  localparam logic [8:0] FAKE_EXP = 9'h04A;
`else
  localparam logic [8:0] FAKE_EXP = 9'h0A5;
`endif

  mitm_logic dut (
    .sys_clk(sys_clk), .rst(rst), .mode_select(mode_select), .comm_active(comm_active),
    .bus_ready(bus_ready), .real_miso_data(real_miso_data), .real_mosi_data(real_mosi_data),
    .cmd_next_chunk(cmd_next_chunk), .cmd_finish(cmd_finish), .next_chunk_size(next_chunk_size),
    .fake_miso_select(fake_miso_select), .fake_mosi_select(fake_mosi_select),
    .fake_miso_data(fake_miso_data), .fake_mosi_data(fake_mosi_data)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {next, finish, size, miso_sel, mosi_sel, miso_data, mosi_data}
  function automatic logic [31:0] outs();
    return 32'({cmd_next_chunk, cmd_finish, next_chunk_size, fake_miso_select,
                fake_mosi_select, fake_miso_data, fake_mosi_data});
  endfunction

  // Bus controller goes busy for one cycle, then presents the chunk with bus_ready high.
  task automatic chunk(input logic [8:0] d);
    bus_ready = 1'b0;
    tick();
    real_mosi_data = d;
    bus_ready = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b0; comm_active = 1'b0; bus_ready = 1'b1; mode_select = 2'b01;
    real_miso_data = 9'h1FF; real_mosi_data = '0;
    tick(); tick();
    chk("reset_outs", outs(), 0);
    rst = 1'b1;

    // FORWARD read
    comm_active = 1'b1;
    tick();
    chk("fwd_instr_req", {cmd_next_chunk, next_chunk_size}, {1'b1, 4'd3});
    tick();
    chk("fwd_instr_pulse_len", cmd_next_chunk, 0);
    chunk(9'h006);
    chk("fwd_addr_req", {cmd_next_chunk, next_chunk_size, fake_miso_select}, {1'b1, 4'd9, 1'b0});
    tick();
    chunk(9'h14A);
    chk("fwd_finish", {cmd_finish, cmd_next_chunk, fake_miso_select}, 3'b100);
    tick();
    chk("fwd_finish_len", cmd_finish, 0);
    comm_active = 1'b0;
    tick();
    chk("fwd_idle", outs(), 0);

    // SUB_ALL read
    mode_select = 2'b10; comm_active = 1'b1;
    tick();
    chk("sub_instr_req", next_chunk_size, 3);
    tick();
    chunk(9'h1FE);
    chk("sub_addr_req", {cmd_next_chunk, next_chunk_size}, {1'b1, 4'd9});
    tick();
    chunk(9'h14A);
    chk("sub_data_req", {cmd_next_chunk, next_chunk_size, fake_miso_select}, {1'b1, 4'd8, 1'b1});
    chk("sub_fake_data", fake_miso_data, FAKE_EXP);
    chk("sub_mosi_fake", {fake_mosi_select, fake_mosi_data}, 0);
    tick();
    chk("sub_sel_busy", {cmd_next_chunk, fake_miso_select}, 2'b01);
    bus_ready = 1'b0;
    tick();
    chk("sub_sel_done", fake_miso_select, 1);
    bus_ready = 1'b1;
    tick();
    chk("sub_finish", {cmd_finish, fake_miso_select, fake_miso_data}, {1'b1, 1'b0, 9'h000});
    tick();
    comm_active = 1'b0;
    tick();
    chk("sub_idle", outs(), 0);

    // SUB_ALL write opcode
    comm_active = 1'b1;
    tick();
    tick();
    chunk(9'h005);
    chk("wr_finish", {cmd_finish, cmd_next_chunk, fake_miso_select, fake_mosi_select}, 4'b1000);
    tick();
    comm_active = 1'b0;
    tick();

    // Unknown mode code behaves as FORWARD
    mode_select = 2'b11; comm_active = 1'b1;
    tick();
    tick();
    chunk(9'h006);
    tick();
    chunk(9'h14A);
    chk("unk_mode_fwd", {cmd_finish, cmd_next_chunk}, 2'b10);
    tick();
    comm_active = 1'b0;
    tick();

    // Abort after address chunk
    mode_select = 2'b10; comm_active = 1'b1;
    tick();
    tick();
    chunk(9'h006);
    tick();
    chunk(9'h14A);
    tick();
    comm_active = 1'b0;
    tick();
    chk("abort_outs", outs(), 0);
    tick();
    chk("abort_no_finish", cmd_finish, 0);

    // Reset mid data chunk
    comm_active = 1'b1;
    tick();
    tick();
    chunk(9'h006);
    tick();
    chunk(9'h14A);
    tick();
    bus_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_mid_outs", outs(), 0);
    rst = 1'b1; bus_ready = 1'b1;
    tick();
    chk("rst_restart", {cmd_next_chunk, next_chunk_size}, {1'b1, 4'd3});
    comm_active = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mitm_logic.md
MITM_LOGIC -- requirements
Module: MitmLogic

Interface
REQ-001 SHALL have parameters (name, default, meaning): BUF_SIZE, 9, chunk buffer width in bits (minimum 8).
REQ-002 SHALL have parameter MODE_WIDTH, 2, width of mode_select.
REQ-003 SHALL have parameters MITM_MODE_FORWARD, 2'b01, and MITM_MODE_SUB_ALL, 2'b10, the mode encodings.
REQ-004 SHALL derive CHUNK_SIZE_WIDTH = clog2(BUF_SIZE+1).
REQ-005 SHALL have port sys_clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-007 SHALL have port mode_select, input, MODE_WIDTH, the requested MITM mode.
REQ-008 SHALL have port comm_active, input, 1, bus transaction (chip select) in progress.
REQ-009 SHALL have port bus_ready, input, 1, bus control idle / chunk complete.
REQ-010 SHALL have ports real_miso_data and real_mosi_data, input, BUF_SIZE, last captured chunk, LSB-aligned.
REQ-011 SHALL have ports cmd_next_chunk and cmd_finish, output, 1, one-cycle command pulses.
REQ-012 SHALL have port next_chunk_size, output, CHUNK_SIZE_WIDTH, bit count of the requested chunk.
REQ-013 SHALL have ports fake_miso_select and fake_mosi_select, output, 1, substitution enables.
REQ-014 SHALL have ports fake_miso_data and fake_mosi_data, output, BUF_SIZE, substitution data.

Function
REQ-015 SHALL implement states IDLE, REQ_INSTR, REQ_ADDR, REQ_DATA, WAIT_BUSY, WAIT_DONE, FINISH, WAIT_END.
REQ-016 IDLE: when comm_active=1 and bus_ready=1, SHALL latch mode_select and go to REQ_INSTR; an unknown mode code SHALL be treated as FORWARD.
REQ-017 Each REQ_* state SHALL assert cmd_next_chunk for exactly one cycle with next_chunk_size valid in that cycle, then enter WAIT_BUSY.
REQ-018 WAIT_BUSY SHALL wait for bus_ready=0; WAIT_DONE SHALL wait for bus_ready=1, then evaluate the chunk just captured in that cycle.
REQ-019 Instruction chunk size SHALL be 3; opcode = real_mosi_data[2:0].
REQ-020 Opcode 3'b110 (read) SHALL go to REQ_ADDR (size BUF_SIZE); any other opcode SHALL go to FINISH.
REQ-021 After the address chunk, FORWARD SHALL go to FINISH; SUB_ALL SHALL latch real_mosi_data as address and go to REQ_DATA (size 8).
REQ-022 In REQ_DATA, fake_miso_select SHALL rise in the same cycle as cmd_next_chunk and stay high until the data chunk completes.
REQ-023 fake_miso_data SHALL be 8'hA5 zero-extended to BUF_SIZE (see REQ-030).
REQ-024 After the data chunk, SHALL go to FINISH and clear fake_miso_select.
REQ-025 FINISH SHALL pulse cmd_finish one cycle (fake selects low) and enter WAIT_END; WAIT_END SHALL return to IDLE when comm_active=0.
REQ-026 comm_active=0 in any non-IDLE state SHALL abort to IDLE next cycle with all outputs cleared; cmd_next_chunk and cmd_finish SHALL never assert together.
REQ-027 fake_mosi_select SHALL be 0 and fake_mosi_data SHALL be all zeros in all modes.

Reset
REQ-028 rst=0 at a rising edge SHALL force IDLE, regardless of state, and clear every output (all commands, selects, next_chunk_size, fake data) to 0.
REQ-029 Latched mode and address SHALL reset to 0; operation SHALL resume from IDLE on the first edge with rst=1.

Configuration
REQ-030 Macro MITM_ADDR_ECHO_EN: when defined, fake_miso_data SHALL equal latched address[7:0] zero-extended; when undefined, it SHALL be 8'hA5 zero-extended.

Verification
REQ-031 FORWARD, read: chunks mosi 3'b110 then 9'h14a -> cmd_next_chunk sizes 3, 9, then one cmd_finish; fake_miso_select stays 0.
REQ-032 SUB_ALL, read: 3'b110, 9'h14a, then data -> sizes 3, 9, 8; fake_miso_select=1 during data chunk; fake_miso_data=9'h0A5 (9'h04A with MITM_ADDR_ECHO_EN); then cmd_finish.
REQ-033 SUB_ALL, write opcode 3'b101 -> one size-3 request, then cmd_finish; no fake selects.
REQ-034 comm_active dropped after address chunk -> IDLE, no cmd_finish, all outputs 0.
REQ-035 rst=0 pulsed mid data chunk -> next edge all outputs 0; a new transaction restarts with a size-3 request.
